// File: rtl/pio_led_pkg.sv
// Shared encodings for the PIO-driven LED controller: control byte layout, LED modes, channel FSM states.
// Pure declarations; no logic, no latency, no flow control.
package pio_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } state_e;

    typedef struct packed {
        logic       trig;
        logic [2:0] burst_m1;
        logic [1:0] mode1;
        logic [1:0] mode0;
    } ctrl_t;

    localparam int BURST_W = 4;

    // Burst field holds pulse count minus one, so 0..7 maps to 1..8 pulses.
    function automatic logic [BURST_W-1:0] burst_len(input logic [2:0] m1);
        return {1'b0, m1} + 4'd1;
    endfunction

endpackage

// File: rtl/pio_led_chan.sv
// One LED channel: off / steady / blink / triggered burst FSM with a half-period phase counter.
// Registered outputs, one clock after the mode/trigger inputs; no backpressure.
module pio_led_chan
    import pio_led_pkg::*;
#(
    parameter int HALF_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode_i,
    input  logic       trig_i,
    input  logic [2:0] burst_m1_i,
    output logic       led_o,
    output logic       busy_o
);

    localparam int CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HALF_CYCLES - 1);

    mode_e                mode;
    mode_e                mode_q, mode_d;
    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic                 led_q, led_d;
    logic                 busy_q, busy_d;
    logic                 mode_chg;
    logic                 phase_end;

    assign mode = mode_e'(mode_i);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        mode_d    = mode;
        mode_chg  = (mode != mode_q);
        phase_end = (cnt_q == CNT_MAX);

        unique case (mode)
            MODE_OFF, MODE_ON: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                burst_d = '0;
            end
            MODE_BLINK: begin
                burst_d = '0;
                if (mode_chg || state_q == ST_IDLE) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end else if (phase_end) begin
                    cnt_d   = '0;
                    state_d = (state_q == ST_ON) ? ST_OFF : ST_ON;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MODE_BURST: begin
                // A busy channel never reaches the trigger check, so re-triggers cannot reload the count.
                if (mode_chg || state_q == ST_IDLE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    burst_d = '0;
                    if (trig_i) begin
                        state_d = ST_ON;
                        burst_d = burst_len(burst_m1_i);
                    end
                end else if (phase_end) begin
                    cnt_d = '0;
                    if (state_q == ST_ON) begin
                        state_d = ST_OFF;
                    end else begin
                        burst_d = burst_q - 1'b1;
                        state_d = (burst_q == BURST_W'(1)) ? ST_IDLE : ST_ON;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        led_d  = (state_d == ST_ON) || (mode == MODE_ON);
        busy_d = (mode == MODE_BURST) && (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= MODE_OFF;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            burst_q <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/pio_led_ctrl.sv
// Two-channel LED controller driven by a PIO byte: registers the byte, detects trigger edges, runs two channels.
// ctrl_i to led_o latency is 2 clocks; no backpressure.
module pio_led_ctrl
    import pio_led_pkg::*;
#(
    parameter int HALF_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ctrl_i,
    output logic [1:0] led_o,
    output logic [1:0] busy_o
);

    ctrl_t ctrl_q, ctrl_d;
    logic  ctrl_vld_q, ctrl_vld_d;
    logic  trig_hist_q, trig_hist_d;
    logic  hist_vld_q, hist_vld_d;
    logic  trig_evt;

    // hist_vld_q keeps the reset value of ctrl_q from counting as a seen 0 on the trigger bit.
    always_comb begin
        ctrl_d      = ctrl_t'(ctrl_i);
        ctrl_vld_d  = 1'b1;
        trig_hist_d = ctrl_q.trig;
        hist_vld_d  = ctrl_vld_q;
        trig_evt    = hist_vld_q & ctrl_q.trig & ~trig_hist_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= '0;
            ctrl_vld_q  <= 1'b0;
            trig_hist_q <= 1'b0;
            hist_vld_q  <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            ctrl_vld_q  <= ctrl_vld_d;
            trig_hist_q <= trig_hist_d;
            hist_vld_q  <= hist_vld_d;
        end
    end

    pio_led_chan #(
        .HALF_CYCLES (HALF_CYCLES)
    ) u_chan0 (
        .clk        (clk),
        .reset      (reset),
        .mode_i     (ctrl_q.mode0),
        .trig_i     (trig_evt),
        .burst_m1_i (ctrl_q.burst_m1),
        .led_o      (led_o[0]),
        .busy_o     (busy_o[0])
    );

    pio_led_chan #(
        .HALF_CYCLES (HALF_CYCLES)
    ) u_chan1 (
        .clk        (clk),
        .reset      (reset),
        .mode_i     (ctrl_q.mode1),
        .trig_i     (trig_evt),
        .burst_m1_i (ctrl_q.burst_m1),
        .led_o      (led_o[1]),
        .busy_o     (busy_o[1])
    );

endmodule

// File: tb/tb_pio_led_ctrl.sv
// Testbench for pio_led_ctrl: directed vector table, multi-cycle scenarios, and randomized control against a timing model.
module tb_pio_led_ctrl;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] ctrl_i = 8'h00;
    logic [1:0] led_o;
    logic [1:0] busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    pio_led_ctrl #(.HALF_CYCLES(H)) dut (
        .clk    (clk),
        .reset  (reset),
        .ctrl_i (ctrl_i),
        .led_o  (led_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: outputs are computed from the edge number at which a blink/burst began.
    int         edge_no = 0;
    int         nsamp   = 0;
    logic [7:0] cq      = 8'h00;
    logic [7:0] pq      = 8'h00;
    int         start_e [2];
    int         npulse  [2];
    bit         bact    [2];
    logic [1:0] mprev   [2];

    task automatic model_edge(input logic r, input logic [7:0] c,
                              output logic [1:0] el, output logic [1:0] eb);
        bit         trig;
        logic [1:0] m;
        bit         running;
        el = 2'b00;
        eb = 2'b00;
        if (r) begin
            nsamp = 0;
            cq    = 8'h00;
            pq    = 8'h00;
            for (int ch = 0; ch < 2; ch++) begin
                bact[ch]  = 1'b0;
                mprev[ch] = 2'b00;
            end
        end else begin
            trig = (nsamp >= 2) && cq[7] && !pq[7];
            for (int ch = 0; ch < 2; ch++) begin
                m = (ch == 0) ? cq[1:0] : cq[3:2];
                case (m)
                    2'b00: begin el[ch] = 1'b0; eb[ch] = 1'b0; end
                    2'b01: begin el[ch] = 1'b1; eb[ch] = 1'b0; end
                    2'b10: begin
                        if (m != mprev[ch]) start_e[ch] = edge_no;
                        el[ch] = ((edge_no - start_e[ch]) % (2*H)) < H;
                        eb[ch] = 1'b0;
                    end
                    default: begin
                        if (m != mprev[ch]) bact[ch] = 1'b0;
                        running = bact[ch] && ((edge_no - 1 - start_e[ch]) < 2*H*npulse[ch]);
                        if (!running && trig) begin
                            bact[ch]    = 1'b1;
                            start_e[ch] = edge_no;
                            npulse[ch]  = int'(cq[6:4]) + 1;
                        end
                        eb[ch] = bact[ch] && ((edge_no - start_e[ch]) < 2*H*npulse[ch]);
                        el[ch] = eb[ch] && (((edge_no - start_e[ch]) % (2*H)) < H);
                    end
                endcase
                mprev[ch] = m;
            end
            pq    = cq;
            cq    = c;
            nsamp = nsamp + 1;
        end
        edge_no = edge_no + 1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic [7:0] c);
        logic [1:0] el, eb;
        reset  = r;
        ctrl_i = c;
        @(posedge clk);
        model_edge(r, c, el, eb);
        #1;
        check("model_led",  {6'b0, led_o},  {6'b0, el});
        check("model_busy", {6'b0, busy_o}, {6'b0, eb});
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] ctrl;
        logic [1:0] led;
        logic [1:0] busy;
    } vec_t;

    vec_t vecs[12];

    task automatic run_burst(input bit retrig, output int pulses, output int busy_cnt);
        logic       prev;
        logic [7:0] c;
        pulses   = 0;
        busy_cnt = 0;
        tick(1'b0, 8'h23);
        tick(1'b0, 8'h23);
        prev = led_o[0];
        for (int k = 0; k < 40; k++) begin
            c = (retrig && k >= 10 && k < 12) ? 8'h23 : 8'hA3;
            tick(1'b0, c);
            if (led_o[0] && !prev) pulses++;
            prev = led_o[0];
            if (busy_o[0]) busy_cnt++;
        end
    endtask

    initial begin
        int         pulses, busy_cnt, len;
        bit         rst_seg;
        logic [7:0] c;

        vecs[0]  = '{1'b1, 8'hFF, 2'b00, 2'b00};
        vecs[1]  = '{1'b1, 8'hFF, 2'b00, 2'b00};
        vecs[2]  = '{1'b1, 8'hFF, 2'b00, 2'b00};
        vecs[3]  = '{1'b0, 8'hFF, 2'b00, 2'b00};
        vecs[4]  = '{1'b0, 8'hFF, 2'b00, 2'b00};
        vecs[5]  = '{1'b0, 8'hFF, 2'b00, 2'b00};
        vecs[6]  = '{1'b0, 8'h01, 2'b00, 2'b00};
        vecs[7]  = '{1'b0, 8'h01, 2'b01, 2'b00};
        vecs[8]  = '{1'b0, 8'h01, 2'b01, 2'b00};
        vecs[9]  = '{1'b0, 8'h01, 2'b01, 2'b00};
        vecs[10] = '{1'b0, 8'h00, 2'b01, 2'b00};
        vecs[11] = '{1'b0, 8'h00, 2'b00, 2'b00};

        for (int i = 0; i < 12; i++) begin
            tick(vecs[i].rst, vecs[i].ctrl);
            check("vec_led",  {6'b0, led_o},  {6'b0, vecs[i].led});
            check("vec_busy", {6'b0, busy_o}, {6'b0, vecs[i].busy});
        end

        // LED1 blink: first edge still shows the old mode, then 4 on / 4 off.
        for (int k = 0; k < 24; k++) begin
            tick(1'b0, 8'h08);
            check("blink_led1", {7'b0, led_o[1]}, {7'b0, (k >= 1) && (((k - 1) % 8) < 4)});
            check("blink_led0", {7'b0, led_o[0]}, 8'h00);
        end
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);

        run_burst(1'b0, pulses, busy_cnt);
        check("burst_pulses", 8'(pulses), 8'd3);
        check("burst_busy_clocks", 8'(busy_cnt), 8'd24);
        check("burst_end_outputs", {2'b0, led_o, 2'b0, busy_o}, 8'h00);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);

        run_burst(1'b1, pulses, busy_cnt);
        check("retrig_pulses", 8'(pulses), 8'd3);
        check("retrig_busy_clocks", 8'(busy_cnt), 8'd24);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);

        tick(1'b0, 8'h23);
        tick(1'b0, 8'h23);
        for (int k = 0; k < 8; k++) tick(1'b0, 8'hA3);
        check("abort_busy_before", {7'b0, busy_o[0]}, 8'h01);
        tick(1'b0, 8'h81);
        tick(1'b0, 8'h81);
        check("abort_led0", {7'b0, led_o[0]}, 8'h01);
        check("abort_busy0", {7'b0, busy_o[0]}, 8'h00);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        check("abort_off_led", {6'b0, led_o}, 8'h00);

        // Mid-burst reset clears outputs on the next edge.
        tick(1'b0, 8'h2F);
        tick(1'b0, 8'hAF);
        tick(1'b0, 8'hAF);
        check("rst_mid_busy_before", {6'b0, busy_o}, 8'h03);
        tick(1'b1, 8'hAF);
        check("rst_mid_outputs", {2'b0, led_o, 2'b0, busy_o}, 8'h00);
        tick(1'b0, 8'hAF);
        tick(1'b0, 8'hAF);
        tick(1'b0, 8'hAF);
        check("rst_no_retrigger", {6'b0, busy_o}, 8'h00);

        for (int seg = 0; seg < 80; seg++) begin
            c       = 8'($urandom);
            len     = int'($urandom_range(1, 24));
            rst_seg = ($urandom_range(0, 29) == 0);
            for (int i = 0; i < len; i++) begin
                tick(rst_seg && (i < 2), (i == len / 2) ? (c ^ 8'h80) : c);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
